// File: rtl/tdc_fine_encoder_pipe.sv
// tdc_fine_encoder_pipe
// Three-stage fine-phase encoder for the TDC: turns a CODE_W-bit thermometer
// code from the delay-line sampling register into an OUT_W-bit phase. It
// supports top-edge or ones-count encoding, a programmable bubble tolerance,
// and registered bubble/error flags.
//
// Optional feature macro: TDC_ENC_BUBBLE_CNT_EN
//   defined   -> saturating bubble/error event counters are built
//   undefined -> bubble_cnt/err_cnt tied to 0, cnt_clr ignored
module tdc_fine_encoder_pipe #(
  parameter  int OUT_W  = 6,
  parameter  int GRP_W  = 8,
  parameter  int CNT_W  = 16,
  localparam int CODE_W = (1 << OUT_W) - 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              din_valid,
  input  logic [CODE_W-1:0] din,
  input  logic              mode,
  input  logic [1:0]        level,
  input  logic              cnt_clr,
  output logic              dout_valid,
  output logic [OUT_W-1:0]  dout,
  output logic              bubble_err,
  output logic              code_err,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // The code is padded with one constant-zero bit on top so that it splits
  // evenly into GRP_W-bit groups.
  localparam int PAD_W  = CODE_W + 1;
  localparam int NGRP   = PAD_W / GRP_W;
  localparam int GIDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int OFF_W  = (GRP_W > 1) ? $clog2(GRP_W) : 1;
  localparam int GCNT_W = $clog2(GRP_W + 1);

  // Number of set bits in one group.
  function automatic logic [GCNT_W-1:0] grp_pop(input logic [GRP_W-1:0] g);
    logic [GCNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < GRP_W; i++) s = s + GCNT_W'(g[i]);
    return s;
  endfunction

  // Index of the highest set bit in one group. The result is 0 when the
  // group is empty, but the caller only uses it for non-empty groups.
  function automatic logic [OFF_W-1:0] grp_top(input logic [GRP_W-1:0] g);
    logic [OFF_W-1:0] r;
    r = '0;
    for (int i = 0; i < GRP_W; i++) if (g[i]) r = OFF_W'(i);
    return r;
  endfunction

  // ---------------- S1: input register ----------------
  logic              v1;
  logic [CODE_W-1:0] d1;
  logic              mode1;
  logic [1:0]        level1;

  // Capture the sampled code and its controls. Data is loaded only on valid
  // cycles so that an idle delay line does not toggle the datapath.
  // NOTE: sequential state is assigned with <= so that every flop samples its
  // pre-edge inputs; blocking = here would make stage order matter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1     <= 1'b0;
      d1     <= '0;
      mode1  <= 1'b0;
      level1 <= '0;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        d1     <= din;
        mode1  <= mode;
        level1 <= level;
      end
    end
  end

  // ---------------- S2: per-group OR / popcount ----------------
  logic [PAD_W-1:0]  dpad;
  logic              any_c;
  logic [GIDX_W-1:0] top_grp_c;
  logic [OFF_W-1:0]  top_off_c;
  logic [GCNT_W-1:0] cnt_c [NGRP];

  assign dpad = {1'b0, d1};

  // Find the highest non-empty group, the top bit inside it, and the
  // ones count of every group.
  // NOTE: every always_comb output gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    any_c     = 1'b0;
    top_grp_c = '0;
    top_off_c = '0;
    for (int g = 0; g < NGRP; g++) begin
      cnt_c[g] = grp_pop(dpad[g*GRP_W +: GRP_W]);
      if (|dpad[g*GRP_W +: GRP_W]) begin
        any_c     = 1'b1;
        top_grp_c = GIDX_W'(g);
        top_off_c = grp_top(dpad[g*GRP_W +: GRP_W]);
      end
    end
  end

  logic              v2;
  logic              any2;
  logic [GIDX_W-1:0] top_grp2;
  logic [OFF_W-1:0]  top_off2;
  logic [GCNT_W-1:0] cnt2 [NGRP];
  logic              mode2;
  logic [1:0]        level2;

  // Register the partial results between the group stage and the final sum.
  // NOTE: the partial-sum array is a bank of pipeline flops and is cleared
  // element by element, so it must not be written like a RAM without reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2       <= 1'b0;
      any2     <= 1'b0;
      top_grp2 <= '0;
      top_off2 <= '0;
      mode2    <= 1'b0;
      level2   <= '0;
      for (int g = 0; g < NGRP; g++) cnt2[g] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        any2     <= any_c;
        top_grp2 <= top_grp_c;
        top_off2 <= top_off_c;
        mode2    <= mode1;
        level2   <= level1;
        for (int g = 0; g < NGRP; g++) cnt2[g] <= cnt_c[g];
      end
    end
  end

  // ---------------- S3: k_top, k_pop, depth, flags ----------------
  logic [OUT_W-1:0] k_top_c;
  logic [OUT_W-1:0] k_pop_c;
  logic [OUT_W-1:0] depth_c;
  logic [OUT_W-1:0] raw_c;
  logic [OUT_W-1:0] dout_c;
  logic             bubble_c;
  logic             err_c;

  // Combine the group results into the final phase and the bubble flags.
  // The constant-zero pad bit means k_top and k_pop never exceed CODE_W.
  always_comb begin
    k_top_c = any2 ? OUT_W'(int'(top_grp2) * GRP_W + int'(top_off2) + 1) : '0;
    k_pop_c = '0;
    for (int g = 0; g < NGRP; g++) k_pop_c = k_pop_c + OUT_W'(cnt2[g]);
    depth_c = k_top_c - k_pop_c;
    raw_c   = mode2 ? k_pop_c : k_top_c;
    // A full-scale code wraps to 0, so the all-ones word only ever means error.
    if (raw_c == OUT_W'(CODE_W)) raw_c = '0;
    bubble_c = (depth_c != '0);
    err_c    = (depth_c > OUT_W'(level2));
    dout_c   = err_c ? '1 : raw_c;
  end

  // Output register. The outputs hold their last value between valid codes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      bubble_err <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      dout_valid <= v2;
      if (v2) begin
        dout       <= dout_c;
        bubble_err <= bubble_c;
        code_err   <= err_c;
      end
    end
  end

  // ---------------- optional event counters ----------------
`ifdef TDC_ENC_BUBBLE_CNT_EN
  // Saturating counters of flagged output words. A clear takes priority
  // over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr) begin
      bubble_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (dout_valid && bubble_err && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
      if (dout_valid && code_err && (err_cnt != '1))      err_cnt    <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign bubble_cnt     = '0;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tdc_fine_encoder_pipe.sv
// Self-checking bench for tdc_fine_encoder_pipe. A reference model computes
// the expected word for every driven code and pushes it to a scoreboard. A
// monitor pops and compares that word whenever dout_valid is seen. Counter
// expectations follow TDC_ENC_BUBBLE_CNT_EN.
module tb_tdc_fine_encoder_pipe;

  localparam int OUT_W  = 6;
  localparam int CODE_W = 63;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [OUT_W-1:0] dout;
    logic             bubble;
    logic             err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              din_valid;
  logic [CODE_W-1:0] din;
  logic              mode;
  logic [1:0]        level;
  logic              cnt_clr;
  logic              dout_valid;
  logic [OUT_W-1:0]  dout;
  logic              bubble_err;
  logic              code_err;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  err_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   run_len = 0;
  int   max_run = 0;

`ifdef TDC_ENC_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  tdc_fine_encoder_pipe #(.OUT_W(OUT_W), .GRP_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din        (din),
    .mode       (mode),
    .level      (level),
    .cnt_clr    (cnt_clr),
    .dout_valid (dout_valid),
    .dout       (dout),
    .bubble_err (bubble_err),
    .code_err   (code_err),
    .bubble_cnt (bubble_cnt),
    .err_cnt    (err_cnt)
  );

  // Reference model, written directly from the definitions: scan for the top
  // bit, count ones, then apply the wrap and the tolerance rules.
  function automatic exp_t model(input logic [CODE_W-1:0] d, input logic m,
                                 input logic [1:0] lv);
    int   ktop, kpop, depth, raw;
    exp_t e;
    ktop = 0;
    for (int i = 0; i < CODE_W; i++) if (d[i]) ktop = i + 1;
    kpop  = $countones(d);
    depth = ktop - kpop;
    raw   = m ? kpop : ktop;
    if (raw == CODE_W) raw = 0;
    e.bubble = (depth != 0);
    e.err    = (depth > int'(lv));
    e.dout   = e.err ? '1 : OUT_W'(raw);
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (dout_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: dout=%0d with empty scoreboard at %0t", dout, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({dout, bubble_err, code_err} !== {e.dout, e.bubble, e.err}) begin
          n_err++;
          $display("FAIL word: got dout=%0d bub=%b err=%b, want dout=%0d bub=%b err=%b at %0t",
                   dout, bubble_err, code_err, e.dout, e.bubble, e.err, $time);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  // All stimulus changes 1 time unit after a rising edge.
  task automatic send(input logic [CODE_W-1:0] d, input logic m, input logic [1:0] lv);
    din_valid = 1'b1;
    din       = d;
    mode      = m;
    level     = lv;
    sb.push_back(model(d, m, lv));
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      @(posedge clk); #1;
      budget++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words still pending, want 0", sb.size());
      sb.delete();
    end
    idle(1);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rstn = 1'b0; din_valid = 1'b1; din = '1; mode = 1'b0; level = 2'd1; cnt_clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({dout_valid, dout, bubble_err, code_err, bubble_cnt, err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b dout=%0d bub=%b err=%b bc=%0d ec=%0d, want all 0",
               dout_valid, dout, bubble_err, code_err, bubble_cnt, err_cnt);
    end
    @(posedge clk); #1;
    rstn = 1'b1; din_valid = 1'b0;
    idle(3);
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_valid: got %b want 0", dout_valid);
    end
    @(posedge clk); #1;
    send('1, 1'b0, 2'd1);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (dout_valid) break;
      @(posedge clk);
      lat++;
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL first_latency: got %0d cycles want 3", lat);
    end
    drain();
  endtask

  task automatic test_midop_reset();
    send(63'h1F, 1'b0, 2'd1);
    send(63'h3B, 1'b1, 2'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (dout_valid !== 1'b0 || dout !== '0) begin
        n_err++;
        $display("FAIL midop_reset: got v=%b dout=%0d want v=0 dout=0", dout_valid, dout);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    send(63'h1F, 1'b0, 2'd1);
    send((63'd1 << 62) - 63'd1, 1'b0, 2'd1);
    send('1, 1'b0, 2'd1);
    send('1, 1'b1, 2'd1);
    send('0, 1'b0, 2'd0);
    send('0, 1'b1, 2'd3);
    drain();
  endtask

  task automatic test_bubble();
    send(63'h3B, 1'b0, 2'd1);
    send(63'h3B, 1'b1, 2'd1);
    send(63'h3B, 1'b0, 2'd0);
    send(63'h3B, 1'b1, 2'd0);
    send(63'd1 << 62, 1'b0, 2'd3);
    send(63'd1 << 62, 1'b1, 2'd3);
    drain();
  endtask

  task automatic test_hold();
    send(63'h3B, 1'b1, 2'd0);
    drain();
    idle(2);
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b0 || dout !== 6'd63 || bubble_err !== 1'b1 || code_err !== 1'b1) begin
      n_err++;
      $display("FAIL hold: got v=%b dout=%0d bub=%b err=%b want v=0 dout=63 bub=1 err=1",
               dout_valid, dout, bubble_err, code_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_deep_bubble();
    logic [CNT_W-1:0] want;
    pulse_clr();
    repeat (3) send(63'h0F0F, 1'($urandom_range(0, 1)), 2'd3);
    drain();
    idle(2);
    want = CNT_EN ? CNT_W'(3) : '0;
    n_vec++;
    if (err_cnt !== want || bubble_cnt !== want) begin
      n_err++;
      $display("FAIL deep_counts: got ec=%0d bc=%0d want %0d", err_cnt, bubble_cnt, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] t;
    max_run = 0;
    for (int n = 0; n < 100; n++) begin
      t = (64'd1 << $urandom_range(0, 63)) - 64'd1;
      send(t[CODE_W-1:0], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    drain();
    n_vec++;
    if (max_run != 100) begin
      n_err++;
      $display("FAIL stream_run: got %0d consecutive valid cycles want 100", max_run);
    end
  endtask

  task automatic test_counters();
    logic [CNT_W-1:0] want;
    pulse_clr();
    for (int n = 0; n < 20; n++) send(63'h0F0F, 1'b0, 2'd3);
    drain();
    idle(2);
    want = CNT_EN ? '1 : '0;
    n_vec++;
    if (err_cnt !== want || bubble_cnt !== want) begin
      n_err++;
      $display("FAIL saturate: got ec=%0d bc=%0d want %0d", err_cnt, bubble_cnt, want);
    end
    pulse_clr();
    send(63'h0F0F, 1'b1, 2'd0);
    idle(2);
    n_vec++;
    if (dout_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clr_align: got dout_valid=%b want 1", dout_valid);
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    idle(2);
    n_vec++;
    if (err_cnt !== '0 || bubble_cnt !== '0) begin
      n_err++;
      $display("FAIL clr_wins: got ec=%0d bc=%0d want 0", err_cnt, bubble_cnt);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_midop_reset();
    test_clean();
    test_bubble();
    test_hold();
    test_deep_bubble();
    test_back_to_back();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
